// File: rtl/x_word_bridge.sv
// UART command bridge: 'W' + 4 bytes loads o_data atomically, 'R' streams a
// snapshot of i_data LSB-first, 'C' clears o_data. Payloads abort on inter-byte timeout.
module x_word_bridge #(
    parameter int unsigned p_timeout = 960000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_byte,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_byte,
    input  logic        i_tx_ready,
    output logic [31:0] o_data,
    input  logic [31:0] i_data,
    output logic        o_busy
);

    localparam int unsigned cnt_w = $clog2(p_timeout) + 1;
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(p_timeout - 1);

    localparam logic [7:0] cmd_write = 8'h57;
    localparam logic [7:0] cmd_read  = 8'h52;
    localparam logic [7:0] cmd_clear = 8'h43;

    typedef enum logic [1:0] {
        st_idle,
        st_payload,
        st_send
    } state_t;

    state_t           state_q, state_n;
    logic [1:0]       idx_q, idx_n;
    logic [cnt_w-1:0] cnt_q, cnt_n;
    logic [31:0]      shadow_q, shadow_n;
    logic [31:0]      snap_q, snap_n;
    logic [31:0]      data_q, data_n;

    // State and datapath registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= st_idle;
            idx_q    <= 2'd0;
            cnt_q    <= '0;
            shadow_q <= 32'd0;
            snap_q   <= 32'd0;
            data_q   <= 32'd0;
        end else begin
            state_q  <= state_n;
            idx_q    <= idx_n;
            cnt_q    <= cnt_n;
            shadow_q <= shadow_n;
            snap_q   <= snap_n;
            data_q   <= data_n;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_n  = state_q;
        idx_n    = idx_q;
        cnt_n    = cnt_q;
        shadow_n = shadow_q;
        snap_n   = snap_q;
        data_n   = data_q;

        case (state_q)
            st_idle: begin
                if (i_rx_valid) begin
                    case (i_rx_byte)
                        cmd_write: begin
                            state_n  = st_payload;
                            idx_n    = 2'd0;
                            cnt_n    = '0;
                            shadow_n = 32'd0;
                        end
                        cmd_read: begin
                            state_n = st_send;
                            idx_n   = 2'd0;
                            snap_n  = i_data;
                        end
                        cmd_clear: data_n = 32'd0;
                        default: ;
                    endcase
                end
            end

            st_payload: begin
                if (i_rx_valid) begin
                    shadow_n[{idx_q, 3'b000} +: 8] = i_rx_byte;
                    cnt_n = '0;
                    if (idx_q == 2'd3) begin
                        // Publish the whole word on the edge that stores the last byte
                        data_n  = {i_rx_byte, shadow_q[23:0]};
                        idx_n   = 2'd0;
                        state_n = st_idle;
                    end else begin
                        idx_n = idx_q + 2'd1;
                    end
                end else if (cnt_q == cnt_last) begin
                    cnt_n   = '0;
                    idx_n   = 2'd0;
                    state_n = st_idle;
                end else begin
                    cnt_n = cnt_q + cnt_w'(1);
                end
            end

            st_send: begin
                if (i_tx_ready) begin
                    if (idx_q == 2'd3) begin
                        idx_n   = 2'd0;
                        state_n = st_idle;
                    end else begin
                        idx_n = idx_q + 2'd1;
                    end
                end
            end

            default: begin
                state_n = st_idle;
                idx_n   = 2'd0;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs decode directly from registered state
    assign o_busy     = (state_q != st_idle);
    assign o_tx_valid = (state_q == st_send);
    assign o_tx_byte  = o_tx_valid ? 8'(snap_q >> {idx_q, 3'b000}) : 8'h00;
    assign o_data     = data_q;

endmodule

// File: tb/tb_x_word_bridge.sv
// Randomised and directed scoreboard bench for x_word_bridge against a
// byte-stream reference model; monitors o_data updates and accepted tx bytes.
module tb_x_word_bridge;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_rx_valid;
    logic [7:0]  i_rx_byte;
    logic        o_tx_valid;
    logic [7:0]  o_tx_byte;
    logic        i_tx_ready;
    logic [31:0] o_data;
    logic [31:0] i_data;
    logic        o_busy;

    x_word_bridge #(.p_timeout(TO)) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_rx_valid (i_rx_valid),
        .i_rx_byte  (i_rx_byte),
        .o_tx_valid (o_tx_valid),
        .o_tx_byte  (o_tx_byte),
        .i_tx_ready (i_tx_ready),
        .o_data     (o_data),
        .i_data     (i_data),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: 0 = idle, 1 = collecting payload, 2 = sending snapshot
    int          mode = 0;
    int          n_byte = 0;
    int          idle_cnt = 0;
    int          sent = 0;
    logic [31:0] mdl_shadow = 32'd0;
    logic [31:0] mdl_data = 32'd0;
    logic [7:0]  exp_tx[$];
    logic [31:0] exp_data[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void set_data(input logic [31:0] v);
        if (v !== mdl_data) exp_data.push_back(v);
        mdl_data = v;
    endfunction

    function automatic void model_edge(input logic v, input logic [7:0] b, input logic rdy);
        case (mode)
            0: if (v) begin
                if (b == 8'h57) begin
                    mode = 1; n_byte = 0; idle_cnt = 0; mdl_shadow = 32'd0;
                end else if (b == 8'h52) begin
                    mode = 2; sent = 0;
                    for (int k = 0; k < 4; k++) exp_tx.push_back(8'(i_data >> (8 * k)));
                end else if (b == 8'h43) begin
                    set_data(32'd0);
                end
            end
            1: if (v) begin
                mdl_shadow = mdl_shadow | (32'(b) << (8 * n_byte));
                n_byte++;
                idle_cnt = 0;
                if (n_byte == 4) begin
                    set_data(mdl_shadow);
                    mode = 0;
                end
            end else begin
                idle_cnt++;
                if (idle_cnt == TO) mode = 0;
            end
            default: if (rdy) begin
                sent++;
                if (sent == 4) mode = 0;
            end
        endcase
    endfunction

    // One clock: drive inputs, advance the model, check status outputs after the edge
    task automatic cyc(input logic v, input logic [7:0] b, input logic rdy);
        i_rx_valid = v;
        i_rx_byte  = v ? b : 8'h00;
        i_tx_ready = rdy;
        model_edge(v, b, rdy);
        @(posedge clk);
        #1;
        i_rx_valid = 1'b0;
        i_rx_byte  = 8'h00;
        chk("busy", 32'(o_busy), 32'(mode != 0));
        chk("tx_valid", 32'(o_tx_valid), 32'(mode == 2));
        if (mode != 2) chk("tx_byte_idle", 32'(o_tx_byte), 32'd0);
    endtask

    task automatic do_reset();
        #2;
        i_rst = 1'b1;
        exp_tx.delete();
        set_data(32'd0);
        mode = 0;
        #1;
        chk("rst_o_data", o_data, 32'd0);
        chk("rst_tx_valid", 32'(o_tx_valid), 32'd0);
        chk("rst_tx_byte", 32'(o_tx_byte), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        @(posedge clk);
        #1;
        i_rst = 1'b0;
    endtask

    // Scoreboard monitor, sampled away from the active edge
    logic [31:0] last_data = 32'd0;
    logic        stalled = 1'b0;
    logic [7:0]  held = 8'h00;

    always @(negedge clk) begin
        if (i_rst) begin
            stalled = 1'b0;
        end else begin
            if (o_data !== last_data) begin
                if (exp_data.size() == 0) chk("o_data_unexpected", o_data, last_data);
                else chk("o_data", o_data, exp_data.pop_front());
                last_data = o_data;
            end
            if (stalled) chk("tx_hold", {23'd0, o_tx_valid, o_tx_byte}, {23'd0, 1'b1, held});
            if (o_tx_valid && i_tx_ready) begin
                if (exp_tx.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL tx_unexpected: got %h expected none at %0t", o_tx_byte, $time);
                end else begin
                    chk("tx_byte", 32'(o_tx_byte), 32'(exp_tx.pop_front()));
                end
            end
            stalled = o_tx_valid && !i_tx_ready;
            held    = o_tx_byte;
        end
    end

    initial begin
        logic [7:0] seq[$];
        int guard;

        i_rst = 1'b1; i_rx_valid = 1'b0; i_rx_byte = 8'h00; i_tx_ready = 1'b0; i_data = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_o_data", o_data, 32'd0);
        chk("reset_busy", 32'(o_busy), 32'd0);
        chk("reset_tx_valid", 32'(o_tx_valid), 32'd0);
        chk("reset_tx_byte", 32'(o_tx_byte), 32'd0);
        i_rst = 1'b0;
        cyc(1'b0, 8'h00, 1'b0);

        // Back-to-back write
        seq = '{8'h57, 8'h78, 8'h56, 8'h34, 8'h12};
        foreach (seq[i]) begin
            if (i == 4) chk("write_not_partial", o_data, 32'd0);
            cyc(1'b1, seq[i], 1'b0);
        end
        chk("write_word", o_data, 32'h12345678);

        // Command bytes inside a payload are data
        seq = '{8'h57, 8'h52, 8'h43, 8'h57, 8'h00};
        foreach (seq[i]) cyc(1'b1, seq[i], 1'b1);
        chk("cmd_as_data", o_data, 32'h00574352);

        // Payload timeout, then clear
        seq = '{8'h57, 8'hAA, 8'hBB};
        foreach (seq[i]) cyc(1'b1, seq[i], 1'b0);
        repeat (20) cyc(1'b0, 8'h00, 1'b0);
        chk("timeout_keeps_data", o_data, 32'h00574352);
        cyc(1'b1, 8'h43, 1'b0);
        chk("clear", o_data, 32'd0);

        // Read with ready tied high
        i_data = 32'hDEADBEEF;
        cyc(1'b1, 8'h52, 1'b1);
        repeat (4) cyc(1'b0, 8'h00, 1'b1);

        // Read with stalls; i_data changes and a stray rx byte arrives mid-send
        cyc(1'b1, 8'h52, 1'b0);
        for (int k = 0; k < 4; k++) begin
            for (int s = 0; s < 10; s++) begin
                if (k == 1 && s == 4) i_data = 32'd0;
                cyc(k == 2 && s == 3, 8'h57, 1'b0);
            end
            cyc(1'b0, 8'h00, 1'b1);
        end

        // Reset mid-payload and mid-send, then read current i_data
        i_data = 32'hCAFEF00D;
        seq = '{8'h57, 8'h11, 8'h22};
        foreach (seq[i]) cyc(1'b1, seq[i], 1'b0);
        do_reset();
        cyc(1'b1, 8'h52, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        do_reset();
        i_data = 32'h0BADC0DE;
        cyc(1'b1, 8'h52, 1'b1);
        repeat (4) cyc(1'b0, 8'h00, 1'b1);

        // Random traffic
        for (int it = 0; it < 1500; it++) begin
            logic [7:0] b;
            logic v;
            int r;
            r = int'($urandom_range(0, 99));
            case ($urandom_range(0, 5))
                0: b = 8'h57;
                1: b = 8'h52;
                2: b = 8'h43;
                default: b = 8'($urandom);
            endcase
            if ($urandom_range(0, 15) == 0) i_data = $urandom;
            if (mode == 1 && r < 4) begin
                repeat ($urandom_range(TO - 2, TO + 1)) cyc(1'b0, 8'h00, 1'b0);
            end else begin
                v = (r < 60);
                cyc(v, b, $urandom_range(0, 2) != 0);
            end
        end

        guard = 0;
        while (mode != 0 && guard < 200) begin
            cyc(1'b0, 8'h00, 1'b1);
            guard++;
        end
        repeat (3) cyc(1'b0, 8'h00, 1'b1);
        chk("tx_queue_drained", 32'(exp_tx.size()), 32'd0);
        chk("data_queue_drained", 32'(exp_data.size()), 32'd0);
        chk("final_o_data", o_data, mdl_data);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/x_word_bridge.md
X_WORD_BRIDGE -- requirements
Module: x_word_bridge

Interface
REQ-001 Parameter: p_timeout, default 960000, W-payload inter-byte timeout in i_clk cycles (10 ms at 96 MHz).
REQ-002 i_clk  input  1  single clock; all logic on rising edge.
REQ-003 i_rst  input  1  reset, asynchronous, active-high.
REQ-004 i_rx_valid  input  1  one-cycle strobe: received UART byte present on i_rx_byte.
REQ-005 i_rx_byte  input  8  received byte, valid only with i_rx_valid.
REQ-006 o_tx_valid  output  1  byte offered to UART transmitter.
REQ-007 o_tx_byte  output  8  byte offered, stable while o_tx_valid high.
REQ-008 i_tx_ready  input  1  transmitter accepts o_tx_byte when high with o_tx_valid.
REQ-009 o_data  output  32  control word driven to the measurement core under test.
REQ-010 i_data  input  32  result word returned from the measurement core.
REQ-011 o_busy  output  1  high whenever state is not IDLE.

Function
REQ-012 States: IDLE, PAYLOAD, SEND; combinational o_busy = (state != IDLE).
REQ-013 IDLE, rx byte 0x57 ('W'): clear payload byte index to 0 and timeout counter to 0; go to PAYLOAD.
REQ-014 PAYLOAD, rx byte: store into shadow register at byte index (index 0 = bits 7:0, little-endian); increment index; reset timeout counter.
REQ-015 PAYLOAD, 4th byte stored: on the same edge, o_data takes full 32-bit shadow value atomically; go to IDLE; o_data never shows partial words.
REQ-016 PAYLOAD, no rx byte: timeout counter increments; at p_timeout-1 with no byte, go to IDLE, o_data unchanged, shadow discarded.
REQ-017 PAYLOAD, rx byte on the timeout cycle: byte wins; stored, counter reset, no abort.
REQ-018 IDLE, rx byte 0x52 ('R'): capture i_data into snapshot register on that edge; byte index = 0; go to SEND.
REQ-019 SEND: o_tx_valid = 1, o_tx_byte = snapshot byte[index], LSB byte first.
REQ-020 SEND: on edge with o_tx_valid && i_tx_ready, index increments; after byte 3 accepted, o_tx_valid falls and state returns to IDLE.
REQ-021 SEND: o_tx_byte and o_tx_valid held stable while i_tx_ready low; no timeout in SEND.
REQ-022 SEND: snapshot not updated by i_data changes; rx bytes arriving in SEND are dropped.
REQ-023 IDLE, rx byte 0x43 ('C'): o_data = 0 next edge; stay IDLE.
REQ-024 IDLE, any other byte: ignored, no state change.
REQ-025 PAYLOAD: bytes 0x57/0x52/0x43 are treated as data, not commands.
REQ-026 Latency: rx byte 'R' at edge N -> o_tx_valid high after edge N; first byte available for acceptance at edge N+1.
REQ-027 o_tx_valid low in IDLE and PAYLOAD; o_tx_byte = 0x00 when o_tx_valid low.
REQ-028 Timeout counter width = clog2(p_timeout)+1; it never wraps; it saturates or is cleared by the abort.

Reset
REQ-029 i_rst high asynchronously forces state IDLE, o_data = 0, o_tx_valid = 0, o_tx_byte = 0, index = 0, counter = 0, shadow = 0, snapshot = 0.
REQ-030 Reset mid-PAYLOAD or mid-SEND aborts with no o_data update and no further tx bytes; first byte after release is decoded in IDLE.

Verification
REQ-031 Rx 57,78,56,34,12 back-to-back -> o_data = 0x12345678 exactly one edge after the 0x12 byte, never partial; o_busy low after.
REQ-032 i_data = 0xDEADBEEF, rx 52, i_tx_ready tied high -> tx EF,BE,AD,DE on four consecutive cycles, then o_tx_valid low.
REQ-033 Rx 52, i_tx_ready low 10 cycles after each byte, i_data changed to 0 mid-send -> same 4 bytes EF,BE,AD,DE, each held stable while stalled.
REQ-034 p_timeout = 16: rx 57,AA,BB, then idle 20 cycles -> return to IDLE at 16 cycles, o_data unchanged; then rx 43 -> o_data = 0.
REQ-035 Reset asserted after 2nd 'W' payload byte and again during SEND byte 1 -> o_data = 0, o_tx_valid = 0 immediately (asynchronous); rx 52 after release returns the current i_data.
REQ-036 Rx 57,52,43,57,00 -> o_data = 0x00574352; no SEND entered.
